hazard_forward_ctrl: RTL and testbench

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

---
 rtl/hazard_forward_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and stall control for the ID stage. It covers load-use stalls and
// slow data-memory loads with a timeout. Define HAZARD_PERF_EN to add the stall-cycle counters.
module hazard_forward_ctrl #(
    parameter int NPORT        = 2,
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5*NPORT-1:0]    ID_rR,
    input  logic [NPORT-1:0]      ID_rf_re,
    input  logic [XLEN*NPORT-1:0] ID_rD,
    input  logic [4:0]            EX_wR,
    input  logic                  EX_rf_we,
    input  logic                  EX_is_load,
    input  logic [XLEN-1:0]       EX_wd,
    input  logic [4:0]            MEM_wR,
    input  logic                  MEM_rf_we,
    input  logic                  MEM_is_load,
    input  logic [XLEN-1:0]       MEM_wd,
    input  logic [XLEN-1:0]       MEM_rd,
    input  logic                  mem_rvalid,
    input  logic [4:0]            WB_wR,
    input  logic                  WB_rf_we,
    input  logic [XLEN-1:0]       WB_wd,
    output logic [XLEN*NPORT-1:0] fwd_rD,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  freeze_back,
`ifdef HAZARD_PERF_EN
    output logic [31:0]           lu_stall_cnt,
    output logic [31:0]           mem_stall_cnt,
`endif
    output logic                  mem_err
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    state_t            state, next_state;
    logic [7:0]        wait_cnt;
    logic [NPORT-1:0]  ex_hit, mem_hit, wb_hit;
    logic              load_use, pending, timeout, hold;

    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (ID_rf_re[k] && (ID_rR[5*k +: 5] != 5'd0)) begin
                ex_hit[k]  = EX_rf_we  && (ID_rR[5*k +: 5] == EX_wR);
                mem_hit[k] = MEM_rf_we && (ID_rR[5*k +: 5] == MEM_wR);
                wb_hit[k]  = WB_rf_we  && (ID_rR[5*k +: 5] == WB_wR);
            end
        end
    end

    always_comb begin
        fwd_rD = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (ex_hit[k])
                fwd_rD[XLEN*k +: XLEN] = EX_wd;
            else if (mem_hit[k])
                fwd_rD[XLEN*k +: XLEN] = MEM_is_load ? MEM_rd : MEM_wd;
            else if (wb_hit[k])
                fwd_rD[XLEN*k +: XLEN] = WB_wd;
            else
                fwd_rD[XLEN*k +: XLEN] = ID_rD[XLEN*k +: XLEN];
        end
    end

    // A timeout overrides a still-pending load so the back end is released for one cycle.
    assign load_use = EX_is_load && (|ex_hit);
    assign pending  = MEM_is_load && MEM_rf_we && !mem_rvalid;
    assign timeout  = (state == MEM_WAIT) && !mem_rvalid && (wait_cnt == 8'(LOAD_TIMEOUT - 1));
    assign hold     = pending && !timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == MEM_WAIT && hold) ? wait_cnt + 8'd1 : '0;
        end
    end

    always_comb begin
        next_state = RUN;
        if (hold)
            next_state = MEM_WAIT;
        else if (load_use)
            next_state = LU_STALL;
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        freeze_back = 1'b0;
        mem_err     = timeout;
        if (hold) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            freeze_back = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (bubble_idex && lu_stall_cnt != '1)
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            if (freeze_back && mem_stall_cnt != '1)
                mem_stall_cnt <= mem_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl (NPORT=2, XLEN=32, LOAD_TIMEOUT=4).
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ID_rR;
    logic [1:0]  ID_rf_re;
    logic [63:0] ID_rD;
    logic [4:0]  EX_wR, MEM_wR, WB_wR;
    logic        EX_rf_we, EX_is_load, MEM_rf_we, MEM_is_load, mem_rvalid, WB_rf_we;
    logic [31:0] EX_wd, MEM_wd, MEM_rd, WB_wd;
    logic [63:0] fwd_rD;
    logic        stall_pc, stall_ifid, bubble_idex, freeze_back, mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] lu_stall_cnt, mem_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.NPORT(2), .XLEN(32), .LOAD_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rR(ID_rR), .ID_rf_re(ID_rf_re), .ID_rD(ID_rD),
        .EX_wR(EX_wR), .EX_rf_we(EX_rf_we), .EX_is_load(EX_is_load), .EX_wd(EX_wd),
        .MEM_wR(MEM_wR), .MEM_rf_we(MEM_rf_we), .MEM_is_load(MEM_is_load), .MEM_wd(MEM_wd),
        .MEM_rd(MEM_rd), .mem_rvalid(mem_rvalid),
        .WB_wR(WB_wR), .WB_rf_we(WB_rf_we), .WB_wd(WB_wd),
        .fwd_rD(fwd_rD), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex), .freeze_back(freeze_back),
`ifdef HAZARD_PERF_EN
        .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
`endif
        .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_rR = '0; ID_rf_re = '0; ID_rD = {32'h0, 32'h1234_0000};
        EX_wR = '0; EX_rf_we = 0; EX_is_load = 0; EX_wd = '0;
        MEM_wR = '0; MEM_rf_we = 0; MEM_is_load = 0; MEM_wd = '0; MEM_rd = '0; mem_rvalid = 0;
        WB_wR = '0; WB_rf_we = 0; WB_wd = '0;
    endtask

    // Outputs {stall_pc, stall_ifid, bubble_idex, freeze_back, mem_err}
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {59'd0, stall_pc, stall_ifid, bubble_idex, freeze_back, mem_err}, {59'd0, exp});
    endtask

    task automatic to_check();  @(negedge clk); endtask
    task automatic next_cycle(); @(posedge clk); #1; endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        to_check();
        check_ctl("reset_ctl", 5'b00000);
`ifdef HAZARD_PERF_EN
        check("reset_lu_cnt", {32'd0, lu_stall_cnt}, 64'd0);
        check("reset_mem_cnt", {32'd0, mem_stall_cnt}, 64'd0);
`endif
        next_cycle();
        rst_n = 1'b1;

        // EX beats MEM; port 1 reads x0 and must see 0 despite a WB write to x0
        ID_rf_re = 2'b11; ID_rR = {5'd0, 5'd5};
        EX_wR = 5'd5; EX_rf_we = 1; EX_wd = 32'h11;
        MEM_wR = 5'd5; MEM_rf_we = 1; MEM_wd = 32'h22;
        WB_wR = 5'd0; WB_rf_we = 1; WB_wd = 32'hFF;
        to_check();
        check("ex_prio", {32'd0, fwd_rD[31:0]}, 64'h11);
        check("x0_port1", {32'd0, fwd_rD[63:32]}, 64'h0);
        check_ctl("x0_no_stall", 5'b00000);
        next_cycle();

        EX_rf_we = 0;
        to_check();
        check("mem_alu", {32'd0, fwd_rD[31:0]}, 64'h22);
        next_cycle();

        MEM_is_load = 1; mem_rvalid = 1; MEM_rd = 32'h33;
        to_check();
        check("mem_load_data", {32'd0, fwd_rD[31:0]}, 64'h33);
        check_ctl("mem_load_ready", 5'b00000);
        next_cycle();

        MEM_rf_we = 0; MEM_is_load = 0; mem_rvalid = 0;
        WB_wR = 5'd5; WB_wd = 32'h44;
        to_check();
        check("wb_fwd", {32'd0, fwd_rD[31:0]}, 64'h44);
        next_cycle();

        clear_inputs();
        ID_rf_re = 2'b10; ID_rR = {5'd9, 5'd5};
        EX_wR = 5'd5; EX_rf_we = 1; EX_wd = 32'h66;
        MEM_wR = 5'd9; MEM_rf_we = 1; MEM_wd = 32'h55;
        to_check();
        check("re_off_regfile", {32'd0, fwd_rD[31:0]}, 64'h1234_0000);
        check("port1_mem", {32'd0, fwd_rD[63:32]}, 64'h55);
        next_cycle();

        // Load-use boundaries: read disabled, then destination x0
        clear_inputs();
        ID_rf_re = 2'b00; ID_rR = {5'd7, 5'd7};
        EX_wR = 5'd7; EX_rf_we = 1; EX_is_load = 1;
        to_check();
        check_ctl("lu_re_off", 5'b00000);
        next_cycle();
        ID_rf_re = 2'b01; ID_rR = {5'd0, 5'd0}; EX_wR = 5'd0;
        to_check();
        check_ctl("lu_x0", 5'b00000);
        next_cycle();

        ID_rR = {5'd0, 5'd7}; EX_wR = 5'd7;
        to_check();
        check_ctl("lu_stall", 5'b11100);
        next_cycle();
        clear_inputs();
        ID_rf_re = 2'b01; ID_rR = {5'd0, 5'd7};
        MEM_wR = 5'd7; MEM_rf_we = 1; MEM_is_load = 1; MEM_rd = 32'hABCD; mem_rvalid = 1;
        to_check();
        check("lu_fwd_load", {32'd0, fwd_rD[31:0]}, 64'hABCD);
        check_ctl("lu_released", 5'b00000);
        next_cycle();

        // Slow load, 3 cycles without rvalid, with a load-use queued behind it
        clear_inputs();
        ID_rf_re = 2'b11; ID_rR = {5'd9, 5'd8};
        MEM_wR = 5'd8; MEM_rf_we = 1; MEM_is_load = 1; MEM_rd = 32'h77;
        EX_wR = 5'd9; EX_rf_we = 1; EX_is_load = 1;
        for (int i = 0; i < 3; i++) begin
            to_check();
            check($sformatf("slow_freeze%0d", i), {59'd0, stall_pc, stall_ifid, bubble_idex, freeze_back, mem_err}, 64'b11010);
            next_cycle();
        end
        mem_rvalid = 1; MEM_rd = 32'hBEEF;
        to_check();
        check("slow_fwd", {32'd0, fwd_rD[31:0]}, 64'hBEEF);
        check_ctl("slow_exit_lu", 5'b11100);
        next_cycle();
        clear_inputs();
        to_check();
        check_ctl("slow_done", 5'b00000);
        next_cycle();

        // Timeout: entry cycle plus three waits frozen, error in the fourth wait cycle
        ID_rf_re = 2'b01; ID_rR = {5'd0, 5'd8};
        MEM_wR = 5'd8; MEM_rf_we = 1; MEM_is_load = 1; MEM_rd = 32'h77;
        for (int i = 0; i < 4; i++) begin
            to_check();
            check($sformatf("to_freeze%0d", i), {59'd0, stall_pc, stall_ifid, bubble_idex, freeze_back, mem_err}, 64'b11010);
            next_cycle();
        end
        to_check();
        check_ctl("to_err", 5'b00001);
        check("to_fwd_raw", {32'd0, fwd_rD[31:0]}, 64'h77);
        next_cycle();
        clear_inputs();
        to_check();
        check_ctl("to_after", 5'b00000);
`ifdef HAZARD_PERF_EN
        check("perf_lu", {32'd0, lu_stall_cnt}, 64'd2);
        check("perf_mem", {32'd0, mem_stall_cnt}, 64'd7);
`endif
        next_cycle();

        // Reset in the second wait cycle aborts the wait and clears the counter
        MEM_wR = 5'd8; MEM_rf_we = 1; MEM_is_load = 1;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        to_check();
        check("rst_mem_err", {63'd0, mem_err}, 64'd0);
`ifdef HAZARD_PERF_EN
        check("rst_lu_cnt", {32'd0, lu_stall_cnt}, 64'd0);
        check("rst_mem_cnt", {32'd0, mem_stall_cnt}, 64'd0);
`endif
        next_cycle();
        clear_inputs();
        to_check();
        check_ctl("rst_released", 5'b00000);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        MEM_wR = 5'd8; MEM_rf_we = 1; MEM_is_load = 1;
        for (int i = 0; i < 4; i++) begin
            to_check();
            check($sformatf("post_rst_freeze%0d", i), {59'd0, stall_pc, stall_ifid, bubble_idex, freeze_back, mem_err}, 64'b11010);
            next_cycle();
        end
        to_check();
        check_ctl("post_rst_err", 5'b00001);
        next_cycle();
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
